// File: rtl/harmonic_sum_engine.sv
// rtl/harmonic_sum_engine.sv - harmonic / alternating harmonic series accumulator
// Reciprocals 2^FRAC_W/k come from a restoring divider, one quotient bit per cycle.
module harmonic_sum_engine #(
  parameter int N_W    = 5,
  parameter int FRAC_W = 16,
  parameter int INT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_W-1:0]          n_in,
  input  logic                    mode,
  input  logic                    clear,
  output logic                    busy,
  output logic                    done,
  output logic [INT_W+FRAC_W-1:0] sum,
  output logic                    ovf,
  output logic [N_W-1:0]          term_k
);

  localparam int SUM_W = INT_W + FRAC_W;
  localparam int Q_W   = FRAC_W + 1;
  localparam int CNT_W = $clog2(FRAC_W + 2);
  localparam logic [Q_W-1:0] DIVIDEND = {1'b1, {FRAC_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, ACC, DONE} state_t;

  state_t             state_q;
  logic [N_W-1:0]     n_q, k_q, rem_q;
  logic               mode_q, busy_q, done_q, ovf_q;
  logic [Q_W-1:0]     dq_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SUM_W-1:0]   acc_q;

  // One restoring step: shift in the next dividend bit, subtract k if it fits.
  logic [N_W:0]       trial_rem, rem_diff;
  logic               trial_ge;
  logic [N_W-1:0]     rem_d;
  logic [Q_W-1:0]     dq_d;

  assign trial_rem = {rem_q, dq_q[Q_W-1]};
  assign rem_diff  = trial_rem - {1'b0, k_q};
  assign trial_ge  = (trial_rem >= {1'b0, k_q});
  assign rem_d     = trial_ge ? rem_diff[N_W-1:0] : trial_rem[N_W-1:0];
  assign dq_d      = {dq_q[Q_W-2:0], trial_ge};

  // Accumulate with one guard bit so both saturation directions are visible.
  logic [SUM_W:0]     add_res, sub_res;
  logic               sub_en;
  logic [SUM_W-1:0]   acc_d;
  logic               ovf_d;

  assign add_res = {1'b0, acc_q} + (SUM_W+1)'(dq_q);
  assign sub_res = {1'b0, acc_q} - (SUM_W+1)'(dq_q);
  assign sub_en  = mode_q & ~k_q[0];

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (sub_en) begin
      if (sub_res[SUM_W]) begin
        acc_d = '0;
        ovf_d = 1'b1;
      end else begin
        acc_d = sub_res[SUM_W-1:0];
      end
    end else begin
      if (add_res[SUM_W]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = add_res[SUM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
    end else if (clear) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (n_in != '0) begin
              n_q     <= n_in;
              mode_q  <= mode;
              k_q     <= N_W'(1);
              rem_q   <= '0;
              dq_q    <= DIVIDEND;
              cnt_q   <= '0;
              state_q <= DIV;
            end else begin
              n_q     <= '0;
              k_q     <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DIV: begin
          rem_q <= rem_d;
          dq_q  <= dq_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAC_W)) state_q <= ACC;
        end
        ACC: begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          if (k_q == n_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            k_q     <= k_q + N_W'(1);
            rem_q   <= '0;
            dq_q    <= DIVIDEND;
            cnt_q   <= '0;
            state_q <= DIV;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          k_q     <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign sum    = acc_q;
  assign ovf    = ovf_q;
  assign term_k = k_q;

endmodule

// File: tb/tb_harmonic_sum_engine.sv
// tb/tb_harmonic_sum_engine.sv - scoreboard bench for harmonic_sum_engine
// Two instances: default widths, and INT_W=1 to force saturation.
module tb_harmonic_sum_engine;

  typedef struct {
    logic [19:0] sum;
    logic        ovf;
    int          cyc;
    int          k;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [4:0]  n0 = '0, n1 = '0;
  logic        mode0 = 1'b0, mode1 = 1'b0;
  logic        clear0 = 1'b0, clear1 = 1'b0;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [19:0] sum0;
  logic [16:0] sum1;
  logic [4:0]  k0, k1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  harmonic_sum_engine dut0 (
    .clk(clk), .rst(rst), .start(start0), .n_in(n0), .mode(mode0), .clear(clear0),
    .busy(busy0), .done(done0), .sum(sum0), .ovf(ovf0), .term_k(k0)
  );

  harmonic_sum_engine #(.N_W(5), .FRAC_W(16), .INT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .n_in(n1), .mode(mode1), .clear(clear1),
    .busy(busy1), .done(done1), .sum(sum1), .ovf(ovf1), .term_k(k1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done0 actual=done required=no_done cyc=%0d", cyc);
      end else begin
        e0 = q0.pop_front();
        if (sum0 !== e0.sum || ovf0 !== e0.ovf || cyc != e0.cyc || busy0 !== 1'b1 || int'(k0) != e0.k) begin
          errors++;
          $display("FAIL result0 actual sum=%h ovf=%b cyc=%0d busy=%b k=%0d required sum=%h ovf=%b cyc=%0d busy=1 k=%0d",
                   sum0, ovf0, cyc, busy0, k0, e0.sum, e0.ovf, e0.cyc, e0.k);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done1 actual=done required=no_done cyc=%0d", cyc);
      end else begin
        e1 = q1.pop_front();
        if ({3'b0, sum1} !== e1.sum || ovf1 !== e1.ovf || cyc != e1.cyc || busy1 !== 1'b1) begin
          errors++;
          $display("FAIL result1 actual sum=%h ovf=%b cyc=%0d required sum=%h ovf=%b cyc=%0d",
                   sum1, ovf1, cyc, e1.sum, e1.ovf, e1.cyc);
        end
      end
    end
  end

  function automatic int pending(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  task automatic run(input int sel, input int n, input logic m, input logic [19:0] es,
                     input logic eo, input bit poke);
    exp_t e;
    int   sc;
    logic b, d;
    @(negedge clk);
    if (sel == 0) begin start0 = 1'b1; n0 = 5'(n); mode0 = m; end
    else          begin start1 = 1'b1; n1 = 5'(n); mode1 = m; end
    @(posedge clk);
    #1;
    sc = cyc;
    e.sum = es; e.ovf = eo; e.cyc = sc + n * 18; e.k = n;
    if (sel == 0) begin q0.push_back(e); start0 = 1'b0; end
    else          begin q1.push_back(e); start1 = 1'b0; end
    if (poke) begin
      repeat (5) @(negedge clk);
      start0 = 1'b1; n0 = 5'd2; mode0 = ~m;
      @(negedge clk);
      start0 = 1'b0; n0 = 5'(n); mode0 = m;
    end
    for (int i = 0; i < 2000 && pending(sel) > 0; i++) begin
      @(negedge clk);
      b = (sel == 0) ? busy0 : busy1;
      d = (sel == 0) ? done0 : done1;
      if (!d && pending(sel) > 0) chk("busy_during_run", {31'b0, b}, 32'd1);
    end
    if (pending(sel) > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_run actual=no_done required=done n=%0d", n);
      if (sel == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic abort(input bit use_rst);
    int found = 0;
    @(negedge clk);
    start0 = 1'b1; n0 = 5'd4; mode0 = 1'b0;
    @(posedge clk);
    #1 start0 = 1'b0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (k0 == 5'd2) found = 1;
    end
    chk("abort_reached_k2", found, 32'd1);
    if (use_rst) begin
      rst = 1'b1;
      #1;
    end else begin
      clear0 = 1'b1;
      @(posedge clk);
      #1 clear0 = 1'b0;
    end
    chk(use_rst ? "rst_busy" : "clr_busy", {31'b0, busy0}, 32'd0);
    chk(use_rst ? "rst_done" : "clr_done", {31'b0, done0}, 32'd0);
    chk(use_rst ? "rst_sum"  : "clr_sum",  {12'b0, sum0}, 32'd0);
    chk(use_rst ? "rst_ovf"  : "clr_ovf",  {31'b0, ovf0}, 32'd0);
    chk(use_rst ? "rst_k"    : "clr_k",    {27'b0, k0},   32'd0);
    if (use_rst) begin
      @(negedge clk);
      rst = 1'b0;
    end
    repeat (60) @(negedge clk);
    chk("abort_idle_busy", {31'b0, busy0}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy0}, 32'd0);
    chk("reset_done", {31'b0, done0}, 32'd0);
    chk("reset_sum",  {12'b0, sum0},  32'd0);
    chk("reset_ovf",  {31'b0, ovf0},  32'd0);
    chk("reset_k",    {27'b0, k0},    32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 4, 1'b0, 20'h21555, 1'b0, 1'b0);
    run(0, 1, 1'b0, 20'h10000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("sum_held", {12'b0, sum0}, 32'h10000);
    chk("idle_k",   {27'b0, k0},   32'd0);
    run(0, 3, 1'b0, 20'h1D555, 1'b0, 1'b0);
    run(0, 4, 1'b1, 20'h09555, 1'b0, 1'b0);
    run(0, 0, 1'b0, 20'h00000, 1'b0, 1'b0);
    run(0, 4, 1'b0, 20'h21555, 1'b0, 1'b1);
    run(1, 4, 1'b0, 20'h1FFFF, 1'b1, 1'b0);
    run(1, 2, 1'b0, 20'h18000, 1'b0, 1'b0);
    run(0, 2, 1'b1, 20'h08000, 1'b0, 1'b0);

    abort(1'b0);
    abort(1'b1);
    run(0, 1, 1'b0, 20'h10000, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
